// File: rtl/lsu_unit.sv
// Multi-cycle RV32I load/store unit: request/grant/response memory handshake,
// byte-lane steering and load extension. Optional LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module lsu_unit #(
    parameter int data_width     = 32,
    parameter int reg_addr_width = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      is_store,
    input  logic [2:0]                funct3,
    input  logic [data_width-1:0]     base,
    input  logic [data_width-1:0]     offset,
    input  logic [data_width-1:0]     store_data,
    input  logic [reg_addr_width-1:0] rd_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [data_width-1:0]     mem_addr,
    output logic [3:0]                mem_be,
    output logic [data_width-1:0]     mem_wdata,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [data_width-1:0]     mem_rdata,
    output logic                      rf_we,
    output logic [reg_addr_width-1:0] rf_waddr,
    output logic [data_width-1:0]     rf_wdata,
    output logic                      misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, WB} state_t;

    state_t state, state_nxt;

    logic [data_width-1:0]     ea;
    logic [data_width-1:0]     addr_p0;
    logic [1:0]                ea_lo_p0;
    logic                      is_store_p0;
    logic [2:0]                funct3_p0;
    logic [reg_addr_width-1:0] rd_p0;
    logic [3:0]                be_p0;
    logic [data_width-1:0]     wdata_p0;
    logic [data_width-1:0]     result_p1;
    logic                      accept;
    logic                      trap_ok;

    function automatic logic [3:0] lane_enables(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic st);
        logic [3:0] be;
        if (!st || f3[1])
            be = 4'b1111;
        else if (f3[0])
            be = lo[1] ? 4'b1100 : 4'b0011;
        else
            be = 4'b0001 << lo;
        return be;
    endfunction

    function automatic logic [data_width-1:0] lane_data(input logic [2:0] f3,
                                                         input logic [data_width-1:0] sd);
        logic [data_width-1:0] wd;
        if (f3[1])
            wd = sd;
        else if (f3[0])
            wd = {2{sd[15:0]}};
        else
            wd = {4{sd[7:0]}};
        return wd;
    endfunction

    // Select the addressed lane, then sign- or zero-extend to full width.
    function automatic logic [data_width-1:0] load_extend(input logic [2:0] f3,
                                                          input logic [1:0] lo,
                                                          input logic [data_width-1:0] rdata);
        logic [4:0]                   amt;
        logic [15:0]                  lane;
        logic signed [7:0]            b_s;
        logic signed [15:0]           h_s;
        logic signed [data_width-1:0] x_s;
        amt  = f3[0] ? {lo[1], 4'b0000} : {lo, 3'b000};
        lane = 16'(rdata >> amt);
        b_s  = $signed(lane[7:0]);
        h_s  = $signed(lane);
        x_s  = '0;
        if (f3[1])
            x_s = $signed(rdata);
        else if (f3[0]) begin
            if (f3[2]) x_s = $signed({{(data_width-16){1'b0}}, lane});
            else       x_s = h_s;
        end else begin
            if (f3[2]) x_s = $signed({{(data_width-8){1'b0}}, lane[7:0]});
            else       x_s = b_s;
        end
        return $unsigned(x_s);
    endfunction

    assign ea     = base + offset;
    assign accept = (state == IDLE) && start;

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis;
    logic mis_p0;

    assign mis = funct3[1] ? (ea[1:0] != 2'b00) : (funct3[0] & ea[0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mis_p0 <= 1'b0;
        else if (accept)
            mis_p0 <= mis;
    end

    assign trap_ok  = !mis_p0;
    assign misalign = (state == WB) && mis_p0;
`else
    assign trap_ok  = 1'b1;
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    state_nxt = mis ? WB : REQ;
`else
                    state_nxt = REQ;
`endif
                end
            end
            REQ:    if (mem_gnt) state_nxt = is_store_p0 ? WB : WAIT_R;
            WAIT_R: if (mem_rvalid) state_nxt = WB;
            WB:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 0: latch the access in the start cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_p0     <= '0;
            ea_lo_p0    <= '0;
            is_store_p0 <= 1'b0;
            funct3_p0   <= '0;
            rd_p0       <= '0;
            be_p0       <= '0;
            wdata_p0    <= '0;
        end else if (accept) begin
            addr_p0     <= {ea[data_width-1:2], 2'b00};
            ea_lo_p0    <= ea[1:0];
            is_store_p0 <= is_store;
            funct3_p0   <= funct3;
            rd_p0       <= rd_addr;
            be_p0       <= lane_enables(funct3, ea[1:0], is_store);
            wdata_p0    <= lane_data(funct3, store_data);
        end
    end

    // Stage 1: capture extracted load data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            result_p1 <= '0;
        else if ((state == WAIT_R) && mem_rvalid)
            result_p1 <= load_extend(funct3_p0, ea_lo_p0, mem_rdata);
    end

    logic load_wb;
    assign load_wb = (state == WB) && !is_store_p0 && trap_ok;

    assign busy      = (state != IDLE);
    assign done      = (state == WB);
    assign mem_req   = (state == REQ);
    assign mem_we    = mem_req && is_store_p0;
    assign mem_addr  = mem_req ? addr_p0 : '0;
    assign mem_be    = mem_req ? be_p0 : '0;
    assign mem_wdata = mem_req ? wdata_p0 : '0;
    assign rf_we     = load_wb && (rd_p0 != '0);
    assign rf_waddr  = load_wb ? rd_p0 : '0;
    assign rf_wdata  = load_wb ? result_p1 : '0;

endmodule

// File: tb/tb_lsu_unit.sv
// Randomized bench for lsu_unit with a transaction-level reference model.
module tb_lsu_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_store, mem_gnt, mem_rvalid;
    logic [2:0]  funct3;
    logic [31:0] base, offset, store_data, mem_rdata;
    logic [4:0]  rd_addr;
    logic        busy, done, mem_req, mem_we, rf_we, misalign;
    logic [31:0] mem_addr, mem_wdata, rf_wdata;
    logic [3:0]  mem_be;
    logic [4:0]  rf_waddr;

    always #5 clk = ~clk;

    lsu_unit dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .base(base), .offset(offset), .store_data(store_data), .rd_addr(rd_addr),
        .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .misalign(misalign)
    );

    int n_chk = 0, n_fail = 0, n_ops = 0, done_cnt = 0;
    bit chk_en = 1'b0;

    logic        exp_busy, exp_done, exp_req, exp_we, exp_rf_we, exp_mis;
    logic [31:0] exp_addr, exp_wdata, exp_rf_wdata;
    logic [3:0]  exp_be;
    logic [4:0]  exp_rf_waddr;
    logic [31:0] last_addr, last_wdata, last_rf_wdata;
    logic [3:0]  last_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        exp_busy = 0; exp_done = 0; exp_req = 0; exp_we = 0; exp_rf_we = 0; exp_mis = 0;
        exp_addr = 0; exp_wdata = 0; exp_rf_wdata = 0; exp_be = 0; exp_rf_waddr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] ea,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        if (f3[1]) return rdata;
        if (f3[0]) begin
            v = (rdata >> (16 * ea[1])) & 32'h0000FFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = (rdata >> (8 * ea[1:0])) & 32'h000000FF;
            if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("mem_req", mem_req, exp_req);
            chk("rf_we", rf_we, exp_rf_we);
            chk("misalign", misalign, exp_mis);
            if (exp_req) begin
                chk("mem_we", mem_we, exp_we);
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_be", mem_be, exp_be);
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
            end
            if (exp_rf_we) begin
                chk("rf_waddr", rf_waddr, exp_rf_waddr);
                chk("rf_wdata", rf_wdata, exp_rf_wdata);
            end
            if (done) done_cnt++;
            if (rf_we) last_rf_wdata = rf_wdata;
            if (mem_req) begin
                last_addr = mem_addr; last_be = mem_be; last_wdata = mem_wdata;
            end
        end
    end

    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] b,
                         input logic [31:0] off, input logic [31:0] sd, input logic [4:0] rd,
                         input int gd, input int rvd, input logic [31:0] rval, input bit extra);
        logic [31:0] ea, wd, res;
        logic [3:0]  be;
        bit          mis, trap;
        ea   = b + off;
        mis  = (f3[1] && ea[1:0] != 2'b00) || (!f3[1] && f3[0] && ea[0]);
        trap = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = mis;
`endif
        if (f3[1]) begin
            be = 4'hF; wd = sd;
        end else if (f3[0]) begin
            be = ea[1] ? 4'hC : 4'h3; wd = (sd & 32'hFFFF) * 32'h00010001;
        end else begin
            be = 4'h1 << ea[1:0]; wd = (sd & 32'hFF) * 32'h01010101;
        end
        if (!st) be = 4'hF;
        res = load_model(f3, ea, rval);
        n_ops++;

        set_idle();
        start = 1; is_store = st; funct3 = f3; base = b; offset = off;
        store_data = sd; rd_addr = rd;
        mem_gnt = 0; mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        step();
        start = 0; base = $urandom; offset = $urandom; store_data = $urandom;
        rd_addr = 5'($urandom); funct3 = 3'($urandom); is_store = 1'($urandom);
        if (!trap) begin
            for (int k = 0; k <= gd; k++) begin
                set_idle();
                exp_busy = 1; exp_req = 1; exp_we = st; exp_addr = ea & 32'hFFFFFFFC;
                exp_be = be; exp_wdata = wd;
                mem_gnt = (k == gd); mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
                start = (extra && k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                step();
            end
            if (!st) begin
                for (int j = 0; j <= rvd; j++) begin
                    set_idle();
                    exp_busy = 1;
                    mem_gnt = 0; mem_rvalid = (j == rvd);
                    mem_rdata = (j == rvd) ? rval : $urandom;
                    start = 1'($urandom_range(0, 1));
                    step();
                end
            end
        end
        set_idle();
        exp_busy = 1; exp_done = 1; exp_mis = trap;
        exp_rf_we = !st && !trap && rd != 0; exp_rf_waddr = rd; exp_rf_wdata = res;
        mem_gnt = 0; mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        start = 1'($urandom_range(0, 1));
        step();
        set_idle();
        start = 0; mem_rvalid = 0;
    endtask

    initial begin
        int d0;
        logic [2:0] f3r;
        logic [31:0] br, offr;
        set_idle();
        rst = 0; start = 0; is_store = 0; funct3 = 0; base = 0; offset = 0; store_data = 0;
        rd_addr = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        last_addr = 0; last_wdata = 0; last_rf_wdata = 0; last_be = 0;
        chk_en = 1;
        step(); step();
        rst = 1;
        step();

        do_op(0, 3'b010, 32'h100, 32'h4, 0, 5'd5, 0, 0, 32'hDEADBEEF, 0);
        chk("lw_addr", last_addr, 32'h00000104);
        chk("lw_be", {28'h0, last_be}, 32'hF);
        chk("lw_data", last_rf_wdata, 32'hDEADBEEF);

        do_op(0, 3'b000, 32'h200, 32'h3, 0, 5'd6, 0, 1, 32'h80FF0000, 0);
        chk("lb_data", last_rf_wdata, 32'hFFFFFF80);
        do_op(0, 3'b100, 32'h200, 32'h3, 0, 5'd6, 1, 0, 32'h80FF0000, 0);
        chk("lbu_data", last_rf_wdata, 32'h00000080);

        do_op(1, 3'b000, 32'h100, 32'h2, 32'h12345678, 5'd0, 0, 0, 0, 0);
        chk("sb_be", {28'h0, last_be}, 32'h4);
        chk("sb_wdata", last_wdata, 32'h78787878);
        do_op(1, 3'b001, 32'h100, 32'h2, 32'h12345678, 5'd0, 0, 0, 0, 0);
        chk("sh_be", {28'h0, last_be}, 32'hC);
        chk("sh_wdata", last_wdata, 32'h56785678);

        d0 = done_cnt;
        do_op(1, 3'b010, 32'h400, 32'h8, 32'hCAFEF00D, 5'd0, 3, 0, 0, 1);
        chk("one_done", done_cnt - d0, 1);

        do_op(0, 3'b010, 32'h0, 32'h0, 0, 5'd0, 0, 0, 32'h7FFFFFFF, 0);

        // Reset while waiting for read data; a late rvalid must be ignored.
        start = 1; is_store = 0; funct3 = 3'b010; base = 32'h300; offset = 0; rd_addr = 5'd7;
        step();
        start = 0; exp_busy = 1; exp_req = 1; exp_we = 0; exp_addr = 32'h300; exp_be = 4'hF;
        mem_gnt = 1;
        step();
        set_idle(); exp_busy = 1; mem_gnt = 0;
        #2;
        rst = 0; set_idle();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rf_we", rf_we, 0);
        step();
        rst = 1;
        step();
        mem_rvalid = 1; mem_rdata = 32'h11111111;
        step();
        mem_rvalid = 0;
        step();

        do_op(0, 3'b010, 32'h100, 32'h2, 0, 5'd9, 0, 0, 32'hA5A5A5A5, 0);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("misal_addr", last_addr, 32'h00000100);
        chk("misal_data", last_rf_wdata, 32'hA5A5A5A5);
`endif

        for (int i = 0; i < 250; i++) begin
            f3r  = 3'($urandom);
            br   = $urandom;
            offr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) br = br & 32'hFFFFFFFC;
            do_op(1'($urandom), f3r, br, offr, $urandom, 5'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                  bit'($urandom_range(0, 1)));
        end
        step();
        chk("done_count", done_cnt, n_ops);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
